cssub16_serial: RTL and testbench

Digit-serial 16-bit borrow-skip subtractor: computes A - B - Bin one 4-bit block per clock. It is the subtract-side counterpart to the 4-block carry-skip adder datapath.
- Each block's borrow either ripples through the block or bypasses it on the skip path when the block fully propagates.
- Operands enter and results leave over valid/ready handshakes, so it drops into the arithmetic test pipelines directly.

---
 rtl/cssub16_serial.sv | 113 +++++++++++
 tb/tb_cssub16_serial.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/cssub16_serial.sv
// Digit-serial 16-bit borrow-skip subtractor: A - B - Bin, one 4-bit block per clock.
// Subtraction is done as A + ~B + ~Bin; a block that fully propagates hands its incoming carry straight on.
module cssub16_serial (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Bin,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] Diff,
  output logic        Bout,
  output logic [2:0]  skip_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] a_q, b_q, diff_q;
  logic        c_q;
  logic [1:0]  idx_q;
  logic [2:0]  skip_q;
  logic        accept, last_blk;

  logic [3:0]  blk_a, blk_nb, blk_s;
  logic        blk_co, blk_p, c_nxt;

  // 4-bit ripple sum of one block; returns {carry_out, sum}
  function automatic logic [4:0] blk_sum(input logic [3:0] a, input logic [3:0] nb, input logic ci);
    logic [4:0] s;
    logic       c;
    c = ci;
    for (int i = 0; i < 4; i++) begin
      s[i] = a[i] ^ nb[i] ^ c;
      c    = (a[i] & nb[i]) | (c & (a[i] ^ nb[i]));
    end
    s[4] = c;
    return s;
  endfunction

  assign accept   = in_valid && in_ready;
  assign last_blk = (idx_q == 2'd3);

  // Block slice selected by the digit index
  always_comb begin
    blk_a           = a_q[{idx_q, 2'b00} +: 4];
    blk_nb          = ~b_q[{idx_q, 2'b00} +: 4];
    {blk_co, blk_s} = blk_sum(blk_a, blk_nb, c_q);
    blk_p           = &(blk_a ^ blk_nb);
    c_nxt           = blk_p ? c_q : blk_co;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RUN;
      S_RUN:   if (last_blk) state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake outputs; in_ready is also held low while reset is asserted
  always_comb begin
    in_ready  = reset_n && (state == S_IDLE);
    out_valid = (state == S_DONE);
  end

  // Serial datapath: operand capture and per-block accumulation
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      idx_q <= 2'd0;
    end else if (state == S_IDLE && accept) begin
      a_q    <= A;
      b_q    <= B;
      c_q    <= ~Bin;
      idx_q  <= 2'd0;
      skip_q <= 3'd0;
    end else if (state == S_RUN) begin
      diff_q[{idx_q, 2'b00} +: 4] <= blk_s;
      c_q    <= c_nxt;
      skip_q <= skip_q + {2'b00, blk_p};
      idx_q  <= idx_q + 2'd1;
    end
  end

  // Result registers load on DONE entry, including the block finishing this cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      Diff     <= 16'd0;
      Bout     <= 1'b0;
      skip_cnt <= 3'd0;
    end else if (state == S_RUN && last_blk) begin
      Diff     <= {blk_s, diff_q[11:0]};
      Bout     <= ~c_nxt;
      skip_cnt <= skip_q + {2'b00, blk_p};
    end
  end

endmodule

// File: tb/tb_cssub16_serial.sv
// Directed testbench for cssub16_serial with hand-computed expected results.
module tb_cssub16_serial;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] A, B;
  logic        Bin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] Diff;
  logic        Bout;
  logic [2:0]  skip_cnt;

  int tests = 0;
  int fails = 0;

  cssub16_serial dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Bin(Bin), .out_valid(out_valid), .out_ready(out_ready),
    .Diff(Diff), .Bout(Bout), .skip_cnt(skip_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one operand set, scramble inputs after the accept edge, and check latency
  task automatic start_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bin);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_ready_before_accept"}, in_ready, 1'b1);
    A = a; B = b; Bin = bin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = 16'(~a); B = 16'(b ^ 16'h5A5A); Bin = ~bin;
    check({tag, "_in_ready_run"}, in_ready, 1'b0);
  endtask

  task automatic finish_op(input string tag, input logic [15:0] ed, input logic eb, input logic [2:0] es);
    tick(); tick();
    tick();
    check({tag, "_not_early"}, out_valid, 1'b0);
    tick();
    check({tag, "_out_valid"}, out_valid, 1'b1);
    check({tag, "_diff"}, Diff, ed);
    check({tag, "_bout"}, Bout, eb);
    check({tag, "_skip"}, skip_cnt, es);
  endtask

  task automatic handshake(input string tag, input logic [15:0] ed);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_drop_valid"}, out_valid, 1'b0);
    check({tag, "_ready_back"}, in_ready, 1'b1);
    check({tag, "_diff_hold"}, Diff, ed);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    A = 16'h0; B = 16'h0; Bin = 1'b0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_diff", Diff, 16'h0);
    check("rst_bout", Bout, 1'b0);
    check("rst_skip", skip_cnt, 3'd0);
    reset_n = 1'b1;
    #1;
    check("idle_in_ready", in_ready, 1'b1);

    start_op("t1", 16'h1234, 16'h0234, 1'b0);
    finish_op("t1", 16'h1000, 1'b0, 3'd3);
    handshake("t1", 16'h1000);

    start_op("t2", 16'h0000, 16'h0001, 1'b0);
    finish_op("t2", 16'hFFFF, 1'b1, 3'd3);
    handshake("t2", 16'hFFFF);

    start_op("t3", 16'hFFFF, 16'hFFFF, 1'b1);
    finish_op("t3", 16'hFFFF, 1'b1, 3'd4);
    handshake("t3", 16'hFFFF);

    start_op("t5", 16'h0005, 16'h0005, 1'b1);
    finish_op("t5", 16'hFFFF, 1'b1, 3'd4);
    handshake("t5", 16'hFFFF);

    // Backpressure with an ignored operand pulse while DONE
    start_op("t4", 16'h8000, 16'h7FFF, 1'b0);
    finish_op("t4", 16'h0001, 1'b0, 3'd0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        A = 16'hAAAA; B = 16'h0000; Bin = 1'b0; in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_diff", Diff, 16'h0001);
      check("bp_bout", Bout, 1'b0);
      check("bp_skip", skip_cnt, 3'd0);
    end
    handshake("bp", 16'h0001);

    // Reset during RUN at block index 2
    start_op("rm", 16'h5555, 16'h1111, 1'b0);
    tick(); tick();
    reset_n = 1'b0;
    tick();
    check("rm_out_valid", out_valid, 1'b0);
    check("rm_diff", Diff, 16'h0);
    check("rm_bout", Bout, 1'b0);
    check("rm_skip", skip_cnt, 3'd0);
    check("rm_in_ready_rst", in_ready, 1'b0);
    reset_n = 1'b1;
    #1;
    check("rm_idle", in_ready, 1'b1);
    tick(); tick();
    check("rm_stays_idle", out_valid, 1'b0);

    start_op("t6", 16'h5555, 16'h1111, 1'b0);
    finish_op("t6", 16'h4444, 1'b0, 3'd0);
    handshake("t6", 16'h4444);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
